change_dispenser: RTL and testbench

Sequential payout engine for the vending machine's change path. Takes the 4-bit change amount produced for a vend or refund, breaks it greedily into coin denominations, and issues one coin at a time to the coin hopper over a valid/ack handshake. Sits between the change calculation and the physical hopper driver, and reports completion back to the vend controller.

---
 rtl/change_dispenser.sv | 148 ++++++++++++++
 tb/tb_change_dispenser.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Greedy coin payout engine: splits a change amount into coins and issues them one at a time over valid/ack.
// Optional DISP_INVENTORY_EN build adds per-denomination stock counters, restock and short reporting.
module change_dispenser #(
  parameter int WIDTH   = 4,
  parameter int DEN_HI  = 5,
  parameter int DEN_MID = 2
`ifdef DISP_INVENTORY_EN
  ,
  parameter int INV_W    = 4,
  parameter int INV_INIT = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] change,
  input  logic             coin_ack,
  output logic             coin_valid,
  output logic [1:0]       coin_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining
`ifdef DISP_INVENTORY_EN
  ,
  input  logic             restock,
  output logic             short
`endif
);

  localparam logic [WIDTH-1:0] L_HI  = WIDTH'(DEN_HI);
  localparam logic [WIDTH-1:0] L_MID = WIDTH'(DEN_MID);
  localparam logic [WIDTH-1:0] L_ONE = WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_ISSUE, S_DONE} state_t;

  state_t           r_state;
  logic             r_coin_valid;
  logic [1:0]       r_coin_sel;
  logic [WIDTH-1:0] r_remaining;

  logic             w_hi_avail;
  logic             w_mid_avail;
  logic             w_lo_avail;
  logic [1:0]       w_pick;
  logic             w_pick_ok;
  logic [WIDTH-1:0] w_coin_val;

`ifdef DISP_INVENTORY_EN
  logic [INV_W-1:0] r_stock [0:2];
  logic             r_short;

  assign w_hi_avail  = (r_stock[2] != '0);
  assign w_mid_avail = (r_stock[1] != '0);
  assign w_lo_avail  = (r_stock[0] != '0);
  assign short       = r_short;
`else
  assign w_hi_avail  = 1'b1;
  assign w_mid_avail = 1'b1;
  assign w_lo_avail  = 1'b1;
`endif

  // Largest coin that fits the balance and is in stock; greedy, never backtracks.
  always_comb begin
    w_pick    = 2'd0;
    w_pick_ok = 1'b1;
    if (r_remaining >= L_HI && w_hi_avail) begin
      w_pick = 2'd2;
    end else if (r_remaining >= L_MID && w_mid_avail) begin
      w_pick = 2'd1;
    end else if (r_remaining >= L_ONE && w_lo_avail) begin
      w_pick = 2'd0;
    end else begin
      w_pick_ok = 1'b0;
    end
  end

  always_comb begin
    w_coin_val = L_ONE;
    case (r_coin_sel)
      2'd2:    w_coin_val = L_HI;
      2'd1:    w_coin_val = L_MID;
      default: w_coin_val = L_ONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_coin_valid <= 1'b0;
      r_coin_sel   <= 2'd0;
      r_remaining  <= '0;
`ifdef DISP_INVENTORY_EN
      r_short      <= 1'b0;
      for (int i = 0; i < 3; i++) r_stock[i] <= INV_W'(INV_INIT);
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_remaining <= change;
`ifdef DISP_INVENTORY_EN
            r_short     <= 1'b0;
`endif
            r_state     <= (change == '0) ? S_DONE : S_SELECT;
          end
        end
        S_SELECT: begin
          if (w_pick_ok) begin
            r_coin_sel   <= w_pick;
            r_coin_valid <= 1'b1;
            r_state      <= S_ISSUE;
          end else begin
`ifdef DISP_INVENTORY_EN
            r_short      <= 1'b1;
`endif
            r_state      <= S_DONE;
          end
        end
        S_ISSUE: begin
          if (coin_ack) begin
            r_remaining  <= r_remaining - w_coin_val;
            r_coin_valid <= 1'b0;
            r_state      <= (r_remaining == w_coin_val) ? S_DONE : S_SELECT;
          end
        end
        default: r_state <= S_IDLE;
      endcase

`ifdef DISP_INVENTORY_EN
      // Restock overrides a same-cycle payout decrement.
      if (restock) begin
        for (int i = 0; i < 3; i++) r_stock[i] <= INV_W'(INV_INIT);
      end else if (r_state == S_ISSUE && coin_ack) begin
        for (int i = 0; i < 3; i++) begin
          if (r_coin_sel == 2'(i) && r_stock[i] != '0) r_stock[i] <= r_stock[i] - 1'b1;
        end
      end
`endif
    end
  end

  assign coin_valid = r_coin_valid;
  assign coin_sel   = r_coin_sel;
  assign remaining  = r_remaining;
  assign busy       = (r_state == S_SELECT) || (r_state == S_ISSUE);
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy payout model queues expected coins, handshakes pop them.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst, start, coin_ack;
  logic [3:0] change;
  logic       coin_valid, busy, done;
  logic [1:0] coin_sel;
  logic [3:0] remaining;
`ifdef DISP_INVENTORY_EN
  logic       restock, short;
  int         m_stock [3];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] rem;
  } coin_t;
  coin_t      sb[$];
  logic [3:0] exp_final;
  bit         exp_short;

  always #5 clk = ~clk;

  change_dispenser #(
    .WIDTH(4), .DEN_HI(5), .DEN_MID(2)
`ifdef DISP_INVENTORY_EN
    , .INV_W(4), .INV_INIT(8)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .change(change), .coin_ack(coin_ack),
    .coin_valid(coin_valid), .coin_sel(coin_sel), .busy(busy), .done(done),
    .remaining(remaining)
`ifdef DISP_INVENTORY_EN
    , .restock(restock), .short(short)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_push(input logic [3:0] chg);
    int rem, d, v;
    int vals[3];
    vals[0] = 1; vals[1] = 2; vals[2] = 5;
    rem = chg;
    exp_short = 1'b0;
    while (rem != 0) begin
      d = -1;
      for (int j = 2; j >= 0; j--) begin
`ifdef DISP_INVENTORY_EN
        if (d < 0 && vals[j] <= rem && m_stock[j] > 0) d = j;
`else
        if (d < 0 && vals[j] <= rem) d = j;
`endif
      end
      if (d < 0) begin
        exp_short = 1'b1;
        break;
      end
      v = vals[d];
      sb.push_back('{sel: 2'(d), rem: 4'(rem)});
      rem = rem - v;
`ifdef DISP_INVENTORY_EN
      m_stock[d] = m_stock[d] - 1;
`endif
    end
    exp_final = 4'(rem);
  endtask

  // Runs one payout; stall = ack-low cycles on the first coin, rnd = random ack, poke = start during payout.
  task automatic pay(input logic [3:0] chg, input int stall, input bit rnd, input bit poke);
    int k, n, stall_left, exp_k;
    bit fin;
    sb.delete();
    model_push(chg);
    n = sb.size();
    exp_k = 2 * n + stall + (exp_short ? 1 : 0);
    start = 1'b1; change = chg; coin_ack = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; stall_left = stall; fin = 1'b0;
    while (!fin) begin
      start = 1'b0;
      if (coin_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL coin_unexpected: coin_sel=%0d remaining=%0d, required no coin (change=%0d)", coin_sel, remaining, chg);
          fin = 1'b1;
        end else if (coin_sel !== sb[0].sel || remaining !== sb[0].rem) begin
          n_fail++;
          $display("FAIL coin_pending: sel=%0d rem=%0d, required sel=%0d rem=%0d (change=%0d)", coin_sel, remaining, sb[0].sel, sb[0].rem, chg);
        end
        if (stall_left > 0 && sb.size() == n) begin
          coin_ack = 1'b0;
          stall_left--;
        end else begin
          coin_ack = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (coin_ack && sb.size() > 0) void'(sb.pop_front());
      end else begin
        coin_ack = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (poke && k == 3) begin
        start = 1'b1; change = 4'd7;
      end
      if (done && !fin) begin
        n_checks++;
        if (remaining !== exp_final || sb.size() != 0 || busy !== 1'b0 || coin_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL done_state: rem=%0d left=%0d busy=%b valid=%b, required rem=%0d left=0 busy=0 valid=0", remaining, sb.size(), busy, coin_valid, exp_final);
        end
        if (!rnd) begin
          n_checks++;
          if (k != exp_k) begin
            n_fail++;
            $display("FAIL done_latency: done after edge %0d, required edge %0d (change=%0d)", k, exp_k, chg);
          end
        end
`ifdef DISP_INVENTORY_EN
        n_checks++;
        if (short !== exp_short) begin
          n_fail++;
          $display("FAIL short_flag: %b, required %b (change=%0d)", short, exp_short, chg);
        end
`endif
        fin = 1'b1;
      end
      if (!fin && k > 300) begin
        n_fail++;
        $display("FAIL done_timeout: no done within 300 cycles (change=%0d)", chg);
        fin = 1'b1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        k++;
      end
    end
    start = 1'b0; coin_ack = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || coin_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b busy=%b valid=%b, required all 0 after done", done, busy, coin_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; coin_ack = 1'b0; change = 4'd0;
`ifdef DISP_INVENTORY_EN
    restock = 1'b0;
    for (int i = 0; i < 3; i++) m_stock[i] = 8;
`endif
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (coin_valid !== 1'b0 || coin_sel !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || remaining !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b sel=%0d busy=%b done=%b rem=%0d, required all 0", coin_valid, coin_sel, busy, done, remaining);
    end
`ifdef DISP_INVENTORY_EN
    n_checks++;
    if (short !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_short: %b, required 0", short);
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_change();
    pay(4'd0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_change13();
    pay(4'd13, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    pay(4'd15, 5, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    pay(4'd13, 0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) pay(4'($urandom_range(1, 15)), 0, 1'b1, 1'b0);
  endtask

  task automatic test_rst_in_issue();
    int w;
    start = 1'b1; change = 4'd7; coin_ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!coin_valid && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    n_checks++;
    if (coin_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_setup: coin_valid=%b, required 1 before reset", coin_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (coin_valid !== 1'b0 || remaining !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_issue: valid=%b rem=%0d busy=%b done=%b, required all 0", coin_valid, remaining, busy, done);
    end
`ifdef DISP_INVENTORY_EN
    for (int i = 0; i < 3; i++) m_stock[i] = 8;
`endif
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_idle: busy=%b done=%b, required idle", busy, done);
    end
  endtask

`ifdef DISP_INVENTORY_EN
  task automatic test_inventory_short();
    for (int i = 0; i < 8; i++) pay(4'd1, 0, 1'b0, 1'b0);
    pay(4'd3, 0, 1'b0, 1'b0);
    n_checks++;
    if (short !== 1'b1 || remaining !== 4'd1) begin
      n_fail++;
      $display("FAIL inv_short: short=%b rem=%0d, required short=1 rem=1", short, remaining);
    end
    restock = 1'b1;
    @(posedge clk); #1;
    restock = 1'b0;
    for (int i = 0; i < 3; i++) m_stock[i] = 8;
    pay(4'd3, 0, 1'b0, 1'b0);
    n_checks++;
    if (short !== 1'b0 || remaining !== 4'd0) begin
      n_fail++;
      $display("FAIL inv_restock: short=%b rem=%0d, required short=0 rem=0", short, remaining);
    end
  endtask

  task automatic test_inventory_hi_stock();
    for (int i = 0; i < 7; i++) pay(4'd5, 0, 1'b0, 1'b0);
    pay(4'd10, 0, 1'b0, 1'b0);
    n_checks++;
    if (dut.r_stock[2] !== 4'd0) begin
      n_fail++;
      $display("FAIL inv_hi_stock: stock=%0d, required 0", dut.r_stock[2]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_change();
    test_change13();
    test_backpressure();
    test_start_ignored();
    test_back_to_back();
    test_rst_in_issue();
`ifdef DISP_INVENTORY_EN
    test_inventory_short();
    test_inventory_hi_stock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
